// File: rtl/cam_cfg_pkg.sv
// Shared definitions for the camera register sequencer: FSM state encoding
// and the default SCCB write address of the sensor.
package cam_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_DELAY,
        ST_DONE,
        ST_ERROR
    } cfg_state_t;

    localparam logic [7:0] DEFAULT_DEV_ADDR = 8'h78;

endpackage

// File: rtl/cfg_delay_timer.sv
// Down-counter for the post-write settling delay: load arms it, and while
// counting it expires after exactly CYCLES counting cycles.
module cfg_delay_timer #(
    parameter int CYCLES = 25000
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic load_i,
    input  logic count_i,
    output logic expire_o
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load_i) begin
            cnt <= LOAD_VAL;
        end else if (count_i && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // The terminal cycle is the one where the count has already reached zero.
    assign expire_o = count_i && (cnt == '0);

endmodule

// File: rtl/cam_reg_sequencer.sv
// Walks a register table and writes each entry to the camera through an SCCB
// master, retrying NACKed writes and pausing once after a chosen entry.
module cam_reg_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int         CLK_FREQ_HZ = 25000000,
    parameter logic [7:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
    parameter int         DELAY_INDEX = 1,
    parameter int         DELAY_MS    = 5,
    parameter int         MAX_RETRY   = 3
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        cfg_start_i,
    output logic [8:0]  reg_index_o,
    input  logic [31:0] reg_data_i,
    input  logic [8:0]  reg_size_i,
    output logic        iic_req_o,
    output logic [7:0]  iic_dev_o,
    output logic [15:0] iic_reg_o,
    output logic [7:0]  iic_wdata_o,
    input  logic        iic_ack_i,
    input  logic        iic_done_i,
    input  logic        iic_nack_i,
    output logic        cfg_busy_o,
    output logic        cfg_done_o,
    output logic        cfg_err_o
);

    localparam int DELAY_CYCLES = CLK_FREQ_HZ / 1000 * DELAY_MS;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
    localparam logic [8:0] DELAY_IDX = 9'(DELAY_INDEX);

    cfg_state_t    state;
    logic [RW-1:0] retry_cnt;
    logic          write_ok;
    logic          delay_load;
    logic          delay_expire;
    logic          advance;
    logic          is_last;
    logic          unused_data;

    assign iic_dev_o   = DEV_ADDR;
    assign unused_data = ^reg_data_i[31:24];

    assign write_ok   = (state == ST_WAIT_DONE) && iic_done_i && !iic_nack_i;
    assign delay_load = write_ok && (reg_index_o == DELAY_IDX);
    assign advance    = (write_ok && (reg_index_o != DELAY_IDX))
                      || ((state == ST_DELAY) && delay_expire);
    assign is_last    = (reg_index_o + 9'd1) == reg_size_i;

    cfg_delay_timer #(
        .CYCLES (DELAY_CYCLES)
    ) u_delay (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .load_i   (delay_load),
        .count_i  (state == ST_DELAY),
        .expire_o (delay_expire)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            reg_index_o <= '0;
            retry_cnt   <= '0;
            iic_req_o   <= 1'b0;
            iic_reg_o   <= '0;
            iic_wdata_o <= '0;
            cfg_busy_o  <= 1'b0;
            cfg_done_o  <= 1'b0;
            cfg_err_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (cfg_start_i) begin
                        reg_index_o <= '0;
                        retry_cnt   <= '0;
                        cfg_done_o  <= 1'b0;
                        cfg_err_o   <= 1'b0;
                        if (reg_size_i == '0) begin
                            state      <= ST_DONE;
                            cfg_done_o <= 1'b1;
                        end else begin
                            state      <= ST_FETCH;
                            cfg_busy_o <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    iic_reg_o   <= reg_data_i[23:8];
                    iic_wdata_o <= reg_data_i[7:0];
                    iic_req_o   <= 1'b1;
                    state       <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (iic_ack_i) begin
                        iic_req_o <= 1'b0;
                        state     <= ST_WAIT_DONE;
                    end
                end
                // Shared by WAIT_DONE and DELAY so both leave through one advance path.
                ST_WAIT_DONE, ST_DELAY: begin
                    if (write_ok) begin
                        retry_cnt <= '0;
                    end
                    if (advance) begin
                        if (is_last) begin
                            state      <= ST_DONE;
                            cfg_busy_o <= 1'b0;
                            cfg_done_o <= 1'b1;
                        end else begin
                            reg_index_o <= reg_index_o + 9'd1;
                            state       <= ST_FETCH;
                        end
                    end else if (delay_load) begin
                        state <= ST_DELAY;
                    end else if ((state == ST_WAIT_DONE) && iic_done_i && iic_nack_i) begin
                        if (retry_cnt < RETRY_LIMIT) begin
                            retry_cnt <= retry_cnt + RW'(1);
                            iic_req_o <= 1'b1;
                            state     <= ST_ISSUE;
                        end else begin
                            state      <= ST_ERROR;
                            cfg_busy_o <= 1'b0;
                            cfg_err_o  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cam_reg_sequencer.sv
// Self-checking bench: a responder plays the SCCB master and compares every
// request against a queue of expected table writes built from the sequencing rules.
module tb_cam_reg_sequencer;

    localparam int CLK_FREQ_HZ  = 1000000;
    localparam int DELAY_MS     = 1;
    localparam int DELAY_INDEX  = 1;
    localparam int MAX_RETRY    = 3;
    localparam int DELAY_CYCLES = CLK_FREQ_HZ / 1000 * DELAY_MS;
    localparam int KIND_RETRY   = 0;
    localparam int KIND_NORMAL  = 1;
    localparam int KIND_DELAY   = 2;

    logic        clk_i;
    logic        rst_n;
    logic        cfg_start_i;
    logic [8:0]  reg_index_o;
    logic [31:0] reg_data_i;
    logic [8:0]  reg_size_i;
    logic        iic_req_o;
    logic [7:0]  iic_dev_o;
    logic [15:0] iic_reg_o;
    logic [7:0]  iic_wdata_o;
    logic        iic_ack_i;
    logic        iic_done_i;
    logic        iic_nack_i;
    logic        cfg_busy_o;
    logic        cfg_done_o;
    logic        cfg_err_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] tbl [4];
    int exp_q[$];
    int issued_q[$];
    int nack_left [4];
    int cyc = 0;
    int resp_state = 0;
    int resp_cnt = 0;
    int cur_idx = 0;
    int have_prev = 0;
    int prev_kind = 0;
    int prev_done_cyc = 0;
    int max_gap = 0;
    int delay_seen = 0;

    cam_reg_sequencer #(
        .CLK_FREQ_HZ (CLK_FREQ_HZ),
        .DELAY_INDEX (DELAY_INDEX),
        .DELAY_MS    (DELAY_MS),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .cfg_start_i (cfg_start_i),
        .reg_index_o (reg_index_o),
        .reg_data_i  (reg_data_i),
        .reg_size_i  (reg_size_i),
        .iic_req_o   (iic_req_o),
        .iic_dev_o   (iic_dev_o),
        .iic_reg_o   (iic_reg_o),
        .iic_wdata_o (iic_wdata_o),
        .iic_ack_i   (iic_ack_i),
        .iic_done_i  (iic_done_i),
        .iic_nack_i  (iic_nack_i),
        .cfg_busy_o  (cfg_busy_o),
        .cfg_done_o  (cfg_done_o),
        .cfg_err_o   (cfg_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    assign reg_data_i = (reg_index_o < 9'd4) ? tbl[reg_index_o[1:0]] : 32'h0;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int expected_gap(input int kind);
        case (kind)
            KIND_RETRY:  return 1;
            KIND_NORMAL: return 2;
            default:     return DELAY_CYCLES + 2;
        endcase
    endfunction

    task automatic check_payload();
        logic [31:0] e;
        e = tbl[exp_q[0]];
        check_output("req_index", 32'(reg_index_o), exp_q[0]);
        check_output("req_reg", 32'(iic_reg_o), 32'(e[23:8]));
        check_output("req_wdata", 32'(iic_wdata_o), 32'(e[7:0]));
    endtask

    // Master responder and per-cycle comparison against the expected write queue.
    always @(negedge clk_i) begin
        cyc++;
        iic_ack_i  = 1'b0;
        iic_done_i = 1'b0;
        iic_nack_i = 1'b0;
        check_output("dev_addr", 32'(iic_dev_o), 32'h78);
        if (!rst_n) begin
            resp_state = 0;
            resp_cnt   = 0;
        end else begin
            case (resp_state)
                0: begin
                    if (exp_q.size() == 0) begin
                        check_output("req_without_pending", 32'(iic_req_o), 0);
                    end else if (iic_req_o) begin
                        cur_idx = exp_q[0];
                        if (have_prev != 0) begin
                            check_output("done_to_req_gap", cyc - prev_done_cyc, expected_gap(prev_kind));
                            if (cyc - prev_done_cyc > max_gap) max_gap = cyc - prev_done_cyc;
                        end
                        check_payload();
                        resp_state = 1;
                        resp_cnt   = 0;
                    end
                end
                1: begin
                    resp_cnt++;
                    check_output("req_held", 32'(iic_req_o), 1);
                    check_payload();
                    if (resp_cnt == 2) begin
                        iic_ack_i = 1'b1;
                        issued_q.push_back(exp_q[0]);
                        void'(exp_q.pop_front());
                        resp_state = 2;
                        resp_cnt   = 0;
                    end
                end
                default: begin
                    resp_cnt++;
                    check_output("req_low_after_ack", 32'(iic_req_o), 0);
                    if (resp_cnt == 10) begin
                        iic_done_i = 1'b1;
                        if (nack_left[cur_idx] > 0) begin
                            iic_nack_i = 1'b1;
                            nack_left[cur_idx]--;
                            prev_kind = KIND_RETRY;
                        end else begin
                            prev_kind = (cur_idx == DELAY_INDEX) ? KIND_DELAY : KIND_NORMAL;
                            if (prev_kind == KIND_DELAY) delay_seen = 1;
                        end
                        prev_done_cyc = cyc;
                        have_prev     = 1;
                        resp_state    = 0;
                    end
                end
            endcase
        end
    end

    task automatic apply_stimulus(input int size, input int n0, input int n1, input int n2, input int n3,
                                  input int poke_a, input int poke_b, input int abort_at, output int waited);
        int nk [4];
        int exp_err;
        int exp_index;
        nk = '{n0, n1, n2, n3};
        exp_q.delete();
        issued_q.delete();
        have_prev  = 0;
        max_gap    = 0;
        delay_seen = 0;
        exp_err    = 0;
        exp_index  = 0;
        for (int i = 0; i < size; i++) begin
            for (int a = 0; a <= ((nk[i] > MAX_RETRY) ? MAX_RETRY : nk[i]); a++) exp_q.push_back(i);
            exp_index = i;
            if (nk[i] > MAX_RETRY) begin
                exp_err = 1;
                break;
            end
        end
        for (int i = 0; i < 4; i++) nack_left[i] = nk[i];
        reg_size_i  = 9'(size);
        cfg_start_i = 1'b1;
        @(negedge clk_i);
        cfg_start_i = 1'b0;
        waited = 0;
        while (!(cfg_busy_o == 1'b0 && (cfg_done_o || cfg_err_o)) && waited < 4000 && waited != abort_at) begin
            cfg_start_i = (waited == poke_a || waited == poke_b) ? 1'b1 : 1'b0;
            @(negedge clk_i);
            waited++;
        end
        cfg_start_i = 1'b0;
        if (waited != abort_at) begin
            check_output("completion_timeout", (waited < 4000) ? 1 : 0, 1);
            check_output("final_done", 32'(cfg_done_o), (exp_err != 0) ? 0 : 1);
            check_output("final_err", 32'(cfg_err_o), exp_err);
            check_output("final_busy", 32'(cfg_busy_o), 0);
            check_output("final_index", 32'(reg_index_o), exp_index);
            check_output("writes_outstanding", exp_q.size(), 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_index"}, 32'(reg_index_o), 0);
        check_output({tag, "_req"}, 32'(iic_req_o), 0);
        check_output({tag, "_reg"}, 32'(iic_reg_o), 0);
        check_output({tag, "_wdata"}, 32'(iic_wdata_o), 0);
        check_output({tag, "_busy"}, 32'(cfg_busy_o), 0);
        check_output({tag, "_done"}, 32'(cfg_done_o), 0);
        check_output({tag, "_err"}, 32'(cfg_err_o), 0);
    endtask

    function automatic int count_issues(input int idx);
        int n = 0;
        foreach (issued_q[i]) if (issued_q[i] == idx) n++;
        return n;
    endfunction

    initial begin
        int waited;
        tbl[0] = 32'h0030_0882;
        tbl[1] = 32'h0031_0303;
        tbl[2] = 32'h0030_17FF;
        tbl[3] = 32'h0030_1856;
        for (int i = 0; i < 4; i++) nack_left[i] = 0;
        rst_n       = 1'b0;
        cfg_start_i = 1'b0;
        reg_size_i  = 9'd0;
        iic_ack_i   = 1'b0;
        iic_done_i  = 1'b0;
        iic_nack_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk_i);
        check_reset_outputs("idle");

        $display("[TB] four-entry table, no NACK");
        apply_stimulus(4, 0, 0, 0, 0, -1, -1, -1, waited);
        check_output("plain_issue_count", issued_q.size(), 4);
        check_output("plain_delay_gap", max_gap, 1002);

        $display("[TB] empty table");
        apply_stimulus(0, 0, 0, 0, 0, -1, -1, -1, waited);
        check_output("empty_done_latency", waited, 0);
        repeat (10) @(negedge clk_i);
        check_output("empty_issue_count", issued_q.size(), 0);

        $display("[TB] index 2 NACKed twice");
        apply_stimulus(4, 0, 0, 2, 0, -1, -1, -1, waited);
        check_output("retry_idx2_issues", count_issues(2), 3);
        check_output("retry_issue_count", issued_q.size(), 6);

        $display("[TB] index 3 NACKed four times");
        apply_stimulus(4, 0, 0, 0, 4, -1, -1, -1, waited);
        check_output("abort_issue_count", issued_q.size(), 7);
        repeat (30) @(negedge clk_i);
        check_output("abort_index_held", 32'(reg_index_o), 3);
        check_output("abort_err_held", 32'(cfg_err_o), 1);

        $display("[TB] start pulses while busy");
        apply_stimulus(4, 0, 0, 0, 0, 40, 600, -1, waited);
        check_output("busy_start_issue_count", issued_q.size(), 4);

        $display("[TB] reset during post-write delay");
        apply_stimulus(4, 0, 0, 0, 0, -1, -1, 500, waited);
        check_output("pre_reset_busy", 32'(cfg_busy_o), 1);
        check_output("pre_reset_in_delay", delay_seen, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        repeat (3) @(negedge clk_i);
        rst_n = 1'b1;
        @(negedge clk_i);
        apply_stimulus(4, 0, 0, 0, 0, -1, -1, -1, waited);
        check_output("post_reset_first_index", (issued_q.size() > 0) ? issued_q[0] : -1, 0);
        check_output("post_reset_issue_count", issued_q.size(), 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        n_errors++;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
